// File: rtl/mem_checker.sv
// mem_checker: fills a memory window with seed+i, reads it back and counts mismatches.
// Optional read timeout enabled by defining MEM_CHECKER_TIMEOUT_EN.
module mem_checker #(
  parameter int TIMEOUT = 15
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [5:0] base_addr,
  input  logic [6:0] count,
  input  logic [7:0] seed,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [6:0] err_cnt,
  output logic [1:0] req_op,
  output logic [5:0] req_addr,
  output logic [7:0] req_data,
  input  logic       rsp_vld,
  input  logic [7:0] rsp_data
);
  typedef enum logic [2:0] {IDLE, WRITE, READ, WAIT, DONE} state_t;
  state_t state, state_d;
  logic [5:0] base, base_d, addr_d;
  logic [6:0] cnt, cnt_d, idx, idx_d, err_d, nxt;
  logic [7:0] sd, sd_d, data_d;
  logic [1:0] op_d;
  logic busy_d, done_d, pass_d, last, tmo, adv, miss;
  assign nxt  = idx + 7'd1;
  assign last = nxt == cnt;
`ifdef MEM_CHECKER_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] tmr, tmr_d;
  assign tmo = !rsp_vld && tmr == TW'(TIMEOUT - 1);
`else
  assign tmo = 1'b0;
`endif
  assign adv  = rsp_vld | tmo;
  assign miss = rsp_vld ? rsp_data != sd + {1'b0, idx} : tmo;
  always_comb begin
    state_d = state;
    base_d  = base;
    cnt_d   = cnt;
    idx_d   = idx;
    sd_d    = sd;
    busy_d  = busy;
    done_d  = 1'b0;
    pass_d  = pass;
    err_d   = err_cnt;
    op_d    = req_op;
    addr_d  = req_addr;
    data_d  = req_data;
`ifdef MEM_CHECKER_TIMEOUT_EN
    tmr_d   = tmr;
`endif
    case (state)
      IDLE: if (start) begin
        base_d  = base_addr;
        sd_d    = seed;
        cnt_d   = count > 7'd64 ? 7'd64 : count;
        idx_d   = '0;
        err_d   = '0;
        pass_d  = 1'b0;
        busy_d  = 1'b1;
        state_d = count == '0 ? DONE : WRITE;
        op_d    = count == '0 ? 2'd0 : 2'd2;
        addr_d  = base_addr;
        data_d  = seed;
      end
      WRITE: begin
        state_d = last ? READ : WRITE;
        idx_d   = last ? 7'd0 : nxt;
        op_d    = last ? 2'd1 : 2'd2;
        addr_d  = last ? base : base + nxt[5:0];
        data_d  = sd + {1'b0, nxt};
      end
      READ: begin
        state_d = WAIT;
        op_d    = 2'd0;
`ifdef MEM_CHECKER_TIMEOUT_EN
        tmr_d   = '0;
`endif
      end
      WAIT: begin
`ifdef MEM_CHECKER_TIMEOUT_EN
        tmr_d = tmr + TW'(1);
`endif
        if (adv) begin
          err_d   = miss && err_cnt != 7'd64 ? err_cnt + 7'd1 : err_cnt;
          state_d = last ? DONE : READ;
          idx_d   = last ? idx : nxt;
          op_d    = last ? 2'd0 : 2'd1;
          addr_d  = last ? req_addr : base + nxt[5:0];
        end
      end
      DONE: begin
        state_d = IDLE;
        done_d  = 1'b1;
        busy_d  = 1'b0;
        pass_d  = err_cnt == '0;
        op_d    = 2'd0;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      base     <= '0;
      cnt      <= '0;
      idx      <= '0;
      sd       <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      pass     <= 1'b0;
      err_cnt  <= '0;
      req_op   <= '0;
      req_addr <= '0;
      req_data <= '0;
`ifdef MEM_CHECKER_TIMEOUT_EN
      tmr      <= '0;
`endif
    end else begin
      state    <= state_d;
      base     <= base_d;
      cnt      <= cnt_d;
      idx      <= idx_d;
      sd       <= sd_d;
      busy     <= busy_d;
      done     <= done_d;
      pass     <= pass_d;
      err_cnt  <= err_d;
      req_op   <= op_d;
      req_addr <= addr_d;
      req_data <= data_d;
`ifdef MEM_CHECKER_TIMEOUT_EN
      tmr      <= tmr_d;
`endif
    end
  end
endmodule

// File: tb/tb_mem_checker.sv
// tb_mem_checker: table-driven check of mem_checker against a behavioural 1-cycle memory.
module tb_mem_checker;
  localparam int TIMEOUT = 15;
  logic clk = 0, rst_n = 0, start = 0;
  logic [5:0] base_addr = '0;
  logic [6:0] count = '0;
  logic [7:0] seed = '0;
  logic busy, done, pass;
  logic [6:0] err_cnt;
  logic [1:0] req_op;
  logic [5:0] req_addr;
  logic [7:0] req_data;
  logic rsp_vld = 1'b0;
  logic [7:0] rsp_data = '0;
  int errors = 0, checks = 0;
  logic [7:0] mem [64];
  bit mem_on = 1;
  int mem_bad = 64;
  typedef struct {
    logic [5:0] base;
    logic [6:0] count;
    logic [7:0] seed;
    int bad;
    bit on;
    int err;
    bit pass;
  } vec_t;
  vec_t tv [7];
  mem_checker #(.TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr), .count(count),
    .seed(seed), .busy(busy), .done(done), .pass(pass), .err_cnt(err_cnt),
    .req_op(req_op), .req_addr(req_addr), .req_data(req_data),
    .rsp_vld(rsp_vld), .rsp_data(rsp_data)
  );
  always #5 clk = ~clk;
  // Memory answers one cycle after a read; bad=64 none, bad=65 every address.
  always @(posedge clk) begin
    if (req_op == 2'd2) mem[req_addr] <= req_data;
    rsp_vld  <= mem_on && req_op == 2'd1;
    rsp_data <= (mem_bad == 65 || mem_bad == int'(req_addr)) ? ~mem[req_addr] : mem[req_addr];
  end
  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask
  task automatic run(input vec_t v);
    int n, wr, rd, bad, cyc, exp_cyc;
    logic [5:0] ea;
    logic [7:0] ed;
    n = v.count > 64 ? 64 : int'(v.count);
    exp_cyc = n + n * (1 + (v.on ? 1 : TIMEOUT)) + 1;
    mem_on = v.on;
    mem_bad = v.bad;
    wr = 0; rd = 0; bad = 0; cyc = 0;
    @(negedge clk);
    base_addr = v.base; count = v.count; seed = v.seed; start = 1;
    @(negedge clk);
    start = 0;
    chk("busy_start", busy, 1);
    while (!done && cyc < 3000) begin
      if (req_op == 2'd2) begin
        ea = v.base + wr[5:0];
        ed = v.seed + wr[7:0];
        if (req_addr != ea || req_data != ed) bad++;
        wr++;
      end
      if (req_op == 2'd1) rd++;
      if (cyc == 2) begin start = 1; base_addr = ~v.base; count = 7'd1; end
      if (cyc == 3) start = 0;
      @(negedge clk);
      cyc++;
    end
    start = 0;
    chk("done_seen", int'(done), 1);
    chk("cycles", cyc, exp_cyc);
    chk("err_cnt", err_cnt, v.err);
    chk("pass", pass, v.pass);
    chk("busy_end", busy, 0);
    chk("writes", wr, n);
    chk("reads", rd, n);
    chk("write_bad", bad, 0);
    @(negedge clk);
    chk("done_width", done, 0);
    chk("pass_hold", pass, v.pass);
  endtask
  task automatic chk_reset_vals();
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_pass", pass, 0);
    chk("rst_err", err_cnt, 0);
    chk("rst_op", req_op, 0);
    chk("rst_addr", req_addr, 0);
    chk("rst_data", req_data, 0);
  endtask
  initial begin
    int dn;
    vec_t tvo;
    tv[0] = '{6'd0,  7'd4,   8'h10, 64, 1'b1, 0,  1'b1};
    tv[1] = '{6'd62, 7'd4,   8'hFE, 64, 1'b1, 0,  1'b1};
    tv[2] = '{6'd0,  7'd8,   8'h80, 5,  1'b1, 1,  1'b0};
    tv[3] = '{6'd10, 7'd0,   8'hAA, 64, 1'b1, 0,  1'b1};
    tv[4] = '{6'd3,  7'd100, 8'h55, 64, 1'b1, 0,  1'b1};
    tv[5] = '{6'd20, 7'd64,  8'h00, 65, 1'b1, 64, 1'b0};
    tv[6] = '{6'd60, 7'd16,  8'hF8, 61, 1'b1, 1,  1'b0};
    repeat (2) @(negedge clk);
    chk_reset_vals();
    rst_n = 1;
    for (int i = 0; i < 7; i++) run(tv[i]);
    tvo = tv[0];
    run(tvo);
    mem_on = 1; mem_bad = 64;
    @(negedge clk);
    base_addr = 0; count = 16; seed = 8'h33; start = 1;
    @(negedge clk);
    start = 0;
    repeat (3) @(negedge clk);
    chk("mid_write_op", req_op, 2);
    rst_n = 0;
    #1;
    chk_reset_vals();
    dn = 0;
    repeat (4) begin @(negedge clk); dn |= int'(done); end
    rst_n = 1;
    repeat (40) begin @(negedge clk); dn |= int'(done); end
    chk("abandon_no_done", dn, 0);
    chk("abandon_busy", busy, 0);
    run(tv[1]);
`ifdef MEM_CHECKER_TIMEOUT_EN
    tvo = '{6'd7, 7'd2, 8'h21, 64, 1'b0, 2, 1'b0};
    run(tvo);
`else
    mem_on = 0;
    @(negedge clk);
    base_addr = 7; count = 2; seed = 8'h21; start = 1;
    @(negedge clk);
    start = 0;
    dn = 0;
    repeat (80) begin @(negedge clk); dn |= int'(done); end
    chk("hang_busy", busy, 1);
    chk("hang_no_done", dn, 0);
    rst_n = 0;
    @(negedge clk);
    rst_n = 1;
    mem_on = 1;
`endif
    run(tv[2]);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
